mips_mem_waitstate: RTL and testbench
=====================================

MIPS_MEM_WAITSTATE -- requirements
Module: mips_mem_waitstate

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit words; power of two; range 16..65536.
REQ-002 Parameter INST_LATENCY, default 1: cycles from instruction request accept to InstMem_Ready; range 1..15.
REQ-003 Parameter DATA_LATENCY, default 1: cycles from data request accept to DataMem_Ready; range 1..15.
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 DataMem_Read  input  1  data read request.
REQ-007 DataMem_Write  input  4  per-byte write enables; bit n covers bits 8n+7..8n.
REQ-008 DataMem_Address  input  30  word address.
REQ-009 DataMem_Out  input  32  write data from the CPU.
REQ-010 DataMem_In  output  32  read data to the CPU.
REQ-011 DataMem_Ready  output  1  one-cycle completion pulse for a data read or write.
REQ-012 InstMem_Read  input  1  instruction fetch request.
REQ-013 InstMem_Address  input  30  word address.
REQ-014 InstMem_In  output  32  fetched instruction.
REQ-015 InstMem_Ready  output  1  one-cycle completion pulse for a fetch.
REQ-016 Mem_Error  output  1  one-cycle pulse with a Ready whose transaction addressed a word >= DEPTH.

Function
REQ-017 Each port has an independent FSM with states IDLE, WAIT and RESP.
REQ-018 A request is accepted in a cycle where the port is in IDLE or RESP and its request is active.
- Data request active: DataMem_Read, or any DataMem_Write bit set.
- Instruction request active: InstMem_Read.
REQ-019 On accept, the port captures the address, byte enables and write data, and loads its counter with LATENCY.
REQ-020 An accepted transaction asserts Ready exactly LATENCY cycles after the accept cycle.
- Ready is high for one cycle per transaction.
- LATENCY=1 with a continuously held request gives Ready every cycle.
REQ-021 Transitions:
- IDLE -> WAIT on accept when LATENCY>1.
- IDLE -> RESP on accept when LATENCY=1.
- WAIT -> RESP when the counter reaches 1.
- RESP -> WAIT/RESP on a new accept, otherwise RESP -> IDLE.
REQ-022 Requests arriving while in WAIT are ignored, not queued; the CPU holds its request until Ready.
REQ-023 When DataMem_Read and a nonzero DataMem_Write are both set, the transaction is a read and the write is discarded.
REQ-024 A data write commits in its Ready cycle; only enabled bytes change; disabled bytes keep their prior value.
REQ-025 Read data is sampled from the array in the Ready cycle and held on DataMem_In/InstMem_In until the next read Ready on that port.
REQ-026 Data writes leave DataMem_In unchanged.
REQ-027 Same-cycle data write commit and instruction read of the same word: InstMem_In returns the newly written value (write-first).
REQ-028 Out-of-range address (>= DEPTH):
- Ready still pulses at normal latency.
- A read returns 32'h0000_0000.
- A write is dropped.
- Mem_Error pulses with that Ready.
REQ-029 Two same-cycle Ready pulses with errors on both ports produce a single Mem_Error pulse.
REQ-030 The array is initialised by simulation load only; it is never cleared by reset.

Reset
REQ-031 While reset is high, both FSMs are forced to IDLE, counters to 0, and requests are not accepted.
REQ-032 Output values while reset is high and on the first cycle after reset: DataMem_Ready=0, InstMem_Ready=0, Mem_Error=0, DataMem_In=0, InstMem_In=0.
REQ-033 Reset asserted mid-transaction aborts it: no Ready is issued and a pending write is not committed.

Structure
REQ-034 Package mips_mem_pkg holds:
- the port state enum (IDLE, WAIT, RESP);
- MAX_LATENCY=15;
- the counter width localparam (4 bits).
REQ-035 Sub-module mips_mem_port_fsm implements accept, counter and Ready generation for one port, parametrised by LATENCY; it is instantiated twice.
REQ-036 The memory array, byte merge and error detection live in mips_mem_waitstate.

Verification
REQ-037 DATA_LATENCY=3: write 32'hDEAD_BEEF, enables 4'hF, to address 5 in cycle 0 -> DataMem_Ready in cycle 3; read of address 5 accepted in cycle 4 -> Ready and DataMem_In=32'hDEAD_BEEF in cycle 7.
REQ-038 Word 8 = 32'h1122_3344; write 32'hAABB_CCDD with enables 4'b0101 -> read of word 8 returns 32'h11BB_33DD.
REQ-039 INST_LATENCY=1: InstMem_Read held 4 cycles on addresses 0,1,2,3 -> four consecutive Ready pulses with matching words.
REQ-040 DEPTH=1024: data read of address 1024 -> Ready at normal latency, DataMem_In=0, Mem_Error=1 in that cycle; write to 2000 leaves the array unchanged.
REQ-041 DATA_LATENCY=4: reset asserted in cycle 2 of a write to address 9 -> no Ready; word 9 unchanged; accepts resume in the cycle after reset deasserts.
REQ-042 DataMem_Read=1 with DataMem_Write=4'hF on address 3 -> treated as a read; word 3 unchanged.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and limits for the wait-state memory model
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } port_state_t;

  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mips_mem_port_fsm.sv
// rtl/mips_mem_port_fsm.sv - per-port accept, latency counter and ready pulse
module mips_mem_port_fsm
  import mips_mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_req,
  output logic o_accept,
  output logic o_ready
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  port_state_t      r_state;
  port_state_t      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    o_accept     = 1'b0;
    o_ready      = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        // Ready is masked during reset so an aborted transaction never completes
        o_ready = (r_state == RESP) && !i_reset;
        if (i_req && !i_reset) begin
          o_accept     = 1'b1;
          w_cnt_next   = LAT_CNT;
          w_state_next = (LATENCY == 1) ? RESP : WAIT;
        end else if (r_state == RESP) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(2)) begin
          w_state_next = RESP;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/mips_mem_waitstate.sv
// rtl/mips_mem_waitstate.sv - dual-port word memory with fixed per-port wait states
module mips_mem_waitstate
  import mips_mem_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int INST_LATENCY = 1,
  parameter int DATA_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        DataMem_Read,
  input  logic [3:0]  DataMem_Write,
  input  logic [29:0] DataMem_Address,
  input  logic [31:0] DataMem_Out,
  output logic [31:0] DataMem_In,
  output logic        DataMem_Ready,
  input  logic        InstMem_Read,
  input  logic [29:0] InstMem_Address,
  output logic [31:0] InstMem_In,
  output logic        InstMem_Ready,
  output logic        Mem_Error
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] r_mem [DEPTH];

  logic [29:0] r_d_addr;
  logic        r_d_rd;
  logic [3:0]  r_d_we;
  logic [31:0] r_d_wdata;
  logic [29:0] r_i_addr;
  logic [31:0] r_d_hold;
  logic [31:0] r_i_hold;

  logic          w_d_req;
  logic          w_d_accept;
  logic          w_d_ready;
  logic          w_i_accept;
  logic          w_i_ready;
  logic          w_d_oor;
  logic          w_i_oor;
  logic [AW-1:0] w_d_idx;
  logic [AW-1:0] w_i_idx;
  logic [31:0]   w_d_word;
  logic [31:0]   w_mask;
  logic [31:0]   w_merged;
  logic          w_commit;
  logic [31:0]   w_d_rdata;
  logic [31:0]   w_i_rdata;

  assign w_d_req = DataMem_Read | (|DataMem_Write);

  mips_mem_port_fsm #(.LATENCY(DATA_LATENCY)) u_data_fsm (
    .i_clk    (clock),
    .i_reset  (reset),
    .i_req    (w_d_req),
    .o_accept (w_d_accept),
    .o_ready  (w_d_ready)
  );

  mips_mem_port_fsm #(.LATENCY(INST_LATENCY)) u_inst_fsm (
    .i_clk    (clock),
    .i_reset  (reset),
    .i_req    (InstMem_Read),
    .o_accept (w_i_accept),
    .o_ready  (w_i_ready)
  );

  // A read with write enables set is a read; the enables are dropped at capture
  always_ff @(posedge clock) begin
    if (w_d_accept) begin
      r_d_addr  <= DataMem_Address;
      r_d_rd    <= DataMem_Read;
      r_d_we    <= DataMem_Read ? 4'h0 : DataMem_Write;
      r_d_wdata <= DataMem_Out;
    end
    if (w_i_accept) begin
      r_i_addr <= InstMem_Address;
    end
  end

  assign w_d_oor  = r_d_addr >= 30'(DEPTH);
  assign w_i_oor  = r_i_addr >= 30'(DEPTH);
  assign w_d_idx  = r_d_addr[AW-1:0];
  assign w_i_idx  = r_i_addr[AW-1:0];
  assign w_d_word = r_mem[w_d_idx];
  assign w_mask   = {{8{r_d_we[3]}}, {8{r_d_we[2]}}, {8{r_d_we[1]}}, {8{r_d_we[0]}}};
  assign w_merged = (w_d_word & ~w_mask) | (r_d_wdata & w_mask);
  assign w_commit = w_d_ready & ~r_d_rd & ~w_d_oor & (|r_d_we);

  assign w_d_rdata = w_d_oor ? 32'h0 : w_d_word;
  // Write-first: a fetch completing alongside a write to the same word sees the new data
  assign w_i_rdata = w_i_oor ? 32'h0 :
                     (w_commit && (w_d_idx == w_i_idx)) ? w_merged : r_mem[w_i_idx];

  always_ff @(posedge clock) begin
    if (w_commit) begin
      r_mem[w_d_idx] <= w_merged;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_d_hold <= 32'h0;
      r_i_hold <= 32'h0;
    end else begin
      if (w_d_ready && r_d_rd) r_d_hold <= w_d_rdata;
      if (w_i_ready)           r_i_hold <= w_i_rdata;
    end
  end

  assign DataMem_Ready = w_d_ready;
  assign InstMem_Ready = w_i_ready;
  assign DataMem_In    = reset ? 32'h0 : ((w_d_ready && r_d_rd) ? w_d_rdata : r_d_hold);
  assign InstMem_In    = reset ? 32'h0 : (w_i_ready ? w_i_rdata : r_i_hold);
  assign Mem_Error     = (w_d_ready & w_d_oor) | (w_i_ready & w_i_oor);

endmodule

// File: tb/tb_mips_mem_waitstate.sv
// tb/tb_mips_mem_waitstate.sv - self-checking bench for mips_mem_waitstate
module tb_mips_mem_waitstate;

  localparam int DEPTH = 1024;
  localparam int DL    = 3;
  localparam int IL    = 1;

  logic        clk;
  logic        reset;
  logic        DataMem_Read;
  logic [3:0]  DataMem_Write;
  logic [29:0] DataMem_Address;
  logic [31:0] DataMem_Out;
  logic [31:0] DataMem_In;
  logic        DataMem_Ready;
  logic        InstMem_Read;
  logic [29:0] InstMem_Address;
  logic [31:0] InstMem_In;
  logic        InstMem_Ready;
  logic        Mem_Error;

  int n_chk  = 0;
  int n_fail = 0;

  mips_mem_waitstate #(.DEPTH(DEPTH), .INST_LATENCY(IL), .DATA_LATENCY(DL)) dut (
    .clock           (clk),
    .reset           (reset),
    .DataMem_Read    (DataMem_Read),
    .DataMem_Write   (DataMem_Write),
    .DataMem_Address (DataMem_Address),
    .DataMem_Out     (DataMem_Out),
    .DataMem_In      (DataMem_In),
    .DataMem_Ready   (DataMem_Ready),
    .InstMem_Read    (InstMem_Read),
    .InstMem_Address (InstMem_Address),
    .InstMem_In      (InstMem_In),
    .InstMem_Ready   (InstMem_Ready),
    .Mem_Error       (Mem_Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transactions complete a fixed number of cycles after acceptance
  logic [31:0] m_mem [int];
  int          mcyc = 0;
  bit          m_d_busy = 0, m_i_busy = 0;
  int          m_d_due, m_i_due, m_d_addr, m_i_addr;
  bit          m_d_rd;
  logic [3:0]  m_d_we;
  logic [31:0] m_d_wd;
  logic [31:0] m_d_hold = 0, m_i_hold = 0;

  function automatic logic [31:0] m_rd(input int a);
    return m_mem.exists(a) ? m_mem[a] : 32'h0;
  endfunction

  always begin : model
    logic        e_dr, e_ir, e_err;
    logic [31:0] mask;
    @(negedge clk);
    e_dr = 0; e_ir = 0; e_err = 0;
    if (reset) begin
      m_d_busy = 0; m_i_busy = 0; m_d_hold = 0; m_i_hold = 0;
    end else begin
      e_dr = m_d_busy && (m_d_due == mcyc);
      e_ir = m_i_busy && (m_i_due == mcyc);
      if (e_dr) begin
        m_d_busy = 0;
        if (m_d_addr >= DEPTH) e_err = 1;
        if (m_d_rd) begin
          m_d_hold = (m_d_addr >= DEPTH) ? 32'h0 : m_rd(m_d_addr);
        end else if (m_d_addr < DEPTH) begin
          for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{m_d_we[b]}};
          m_mem[m_d_addr] = (m_rd(m_d_addr) & ~mask) | (m_d_wd & mask);
        end
      end
      if (e_ir) begin
        m_i_busy = 0;
        if (m_i_addr >= DEPTH) e_err = 1;
        m_i_hold = (m_i_addr >= DEPTH) ? 32'h0 : m_rd(m_i_addr);
      end
    end
    chk("m_d_ready", {31'h0, DataMem_Ready}, {31'h0, e_dr});
    chk("m_i_ready", {31'h0, InstMem_Ready}, {31'h0, e_ir});
    chk("m_err",     {31'h0, Mem_Error},     {31'h0, e_err});
    chk("m_d_in",    DataMem_In, m_d_hold);
    chk("m_i_in",    InstMem_In, m_i_hold);
    @(posedge clk);
    if (!reset) begin
      if ((DataMem_Read || DataMem_Write != 4'h0) && !m_d_busy) begin
        m_d_busy = 1; m_d_due = mcyc + DL; m_d_addr = int'(DataMem_Address);
        m_d_rd = DataMem_Read; m_d_we = DataMem_Write; m_d_wd = DataMem_Out;
      end
      if (InstMem_Read && !m_i_busy) begin
        m_i_busy = 1; m_i_due = mcyc + IL; m_i_addr = int'(InstMem_Address);
      end
    end
    mcyc++;
  end

  task automatic wait_d_ready(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (DataMem_Ready) break;
      lat++;
    end
    if (lat == 20) begin
      n_chk++; n_fail++;
      $display("FAIL d_timeout: got no DataMem_Ready expected one within 20 cycles");
    end
  endtask

  task automatic d_txn(input logic rd, input logic [3:0] we, input logic [29:0] addr,
                       input logic [31:0] wd, output logic [31:0] rdata, output int lat,
                       output logic err);
    @(posedge clk); #1;
    DataMem_Read = rd; DataMem_Write = we; DataMem_Address = addr; DataMem_Out = wd;
    wait_d_ready(lat);
    rdata = DataMem_In; err = Mem_Error;
    #1;
    DataMem_Read = 0; DataMem_Write = 4'h0;
  endtask

  logic [31:0] iw [4];
  logic [31:0] rdata;
  logic        err;
  int          lat;

  initial begin
    iw[0] = 32'h2408_0001; iw[1] = 32'h2409_0002; iw[2] = 32'h012A_5820; iw[3] = 32'hAD0B_0004;
    reset = 1; DataMem_Read = 0; DataMem_Write = 0; DataMem_Address = 0; DataMem_Out = 0;
    InstMem_Read = 0; InstMem_Address = 0;
    repeat (3) @(negedge clk);
    chk("rst_d_ready", {31'h0, DataMem_Ready}, 32'h0);
    chk("rst_d_in", DataMem_In, 32'h0);
    chk("rst_i_in", InstMem_In, 32'h0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("post_rst_ready", {30'h0, DataMem_Ready, InstMem_Ready}, 32'h0);
    chk("post_rst_err", {31'h0, Mem_Error}, 32'h0);

    for (int k = 0; k < 4; k++) d_txn(0, 4'hF, 30'(k), iw[k], rdata, lat, err);
    d_txn(0, 4'hF, 9, 32'h0000_0999, rdata, lat, err);
    d_txn(0, 4'hF, 976, 32'h5A5A_0976, rdata, lat, err);

    // write then read back with a 3-cycle data latency
    d_txn(0, 4'hF, 5, 32'hDEAD_BEEF, rdata, lat, err);
    chk("wr5_lat", 32'(lat), 32'd3);
    d_txn(1, 4'h0, 5, 32'h0, rdata, lat, err);
    chk("rd5_lat", 32'(lat), 32'd3);
    chk("rd5_data", rdata, 32'hDEAD_BEEF);

    // byte-enable merge
    d_txn(0, 4'hF, 8, 32'h1122_3344, rdata, lat, err);
    d_txn(0, 4'b0101, 8, 32'hAABB_CCDD, rdata, lat, err);
    d_txn(1, 4'h0, 8, 32'h0, rdata, lat, err);
    chk("merge8", rdata, 32'h11BB_33DD);

    // streaming fetch, one Ready per cycle
    @(posedge clk); #1 InstMem_Read = 1; InstMem_Address = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) InstMem_Address = 30'(k); else InstMem_Read = 0;
      @(negedge clk);
      chk("if_ready", {31'h0, InstMem_Ready}, 32'h1);
      chk("if_data", InstMem_In, iw[k-1]);
    end

    // out-of-range read and dropped out-of-range write
    d_txn(1, 4'h0, 1024, 32'h0, rdata, lat, err);
    chk("oor_lat", 32'(lat), 32'd3);
    chk("oor_data", rdata, 32'h0);
    chk("oor_err", {31'h0, err}, 32'h1);
    d_txn(0, 4'hF, 2000, 32'hFFFF_FFFF, rdata, lat, err);
    chk("oor_wr_err", {31'h0, err}, 32'h1);
    d_txn(1, 4'h0, 976, 32'h0, rdata, lat, err);
    chk("oor_wr_alias", rdata, 32'h5A5A_0976);

    // reset mid-write aborts it
    @(posedge clk); #1 DataMem_Write = 4'hF; DataMem_Address = 9; DataMem_Out = 32'h0BAD_0BAD;
    @(posedge clk); @(posedge clk); #1 reset = 1; DataMem_Write = 4'h0;
    @(negedge clk);
    chk("abort_ready", {31'h0, DataMem_Ready}, 32'h0);
    @(posedge clk); #1 reset = 0; DataMem_Read = 1; DataMem_Address = 9;
    wait_d_ready(lat);
    chk("resume_lat", 32'(lat), 32'd3);
    chk("abort_word9", DataMem_In, 32'h0000_0999);
    #1 DataMem_Read = 0;

    // read wins over simultaneous write enables
    d_txn(1, 4'hF, 3, 32'hFFFF_FFFF, rdata, lat, err);
    chk("rdwr_data", rdata, iw[3]);
    d_txn(1, 4'h0, 3, 32'h0, rdata, lat, err);
    chk("rdwr_word3", rdata, iw[3]);

    // write-first on a same-cycle data write and fetch of word 1
    @(posedge clk); #1 DataMem_Write = 4'hF; DataMem_Address = 1; DataMem_Out = 32'hCAFE_F00D;
    @(posedge clk); @(posedge clk); #1 InstMem_Read = 1; InstMem_Address = 1;
    @(negedge clk); @(negedge clk);
    chk("wf_ready", {30'h0, DataMem_Ready, InstMem_Ready}, 32'h3);
    chk("wf_data", InstMem_In, 32'hCAFE_F00D);
    #1 DataMem_Write = 0; InstMem_Read = 0;

    // both ports out of range on the same cycle
    @(posedge clk); #1 DataMem_Read = 1; DataMem_Address = 1024;
    @(posedge clk); @(posedge clk); #1 InstMem_Read = 1; InstMem_Address = 1500;
    @(negedge clk); @(negedge clk);
    chk("dual_ready", {30'h0, DataMem_Ready, InstMem_Ready}, 32'h3);
    chk("dual_err", {31'h0, Mem_Error}, 32'h1);
    chk("dual_i_in", InstMem_In, 32'h0);
    #1 DataMem_Read = 0; InstMem_Read = 0;
    @(negedge clk);
    chk("dual_err_pulse", {31'h0, Mem_Error}, 32'h0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no end of test expected finish before 50000");
    $fatal(1);
  end

endmodule
